// File: rtl/pong_pkg.sv
// Shared encodings for the pong game sequencer: FSM states, winner codes
// and score width.
package pong_pkg;

  localparam int SCORE_W = 4;

  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_SERVE     = 3'd1;
  localparam logic [2:0] ENC_RUNNING   = 3'd2;
  localparam logic [2:0] ENC_SCORE     = 3'd3;
  localparam logic [2:0] ENC_GAME_OVER = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ENC_IDLE,
    SERVE     = ENC_SERVE,
    RUNNING   = ENC_RUNNING,
    SCORE     = ENC_SCORE,
    GAME_OVER = ENC_GAME_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: previous-sample register resets high so a signal
// already high out of reset does not report an edge.
module rise_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sig_q <= 1'b1;
    else          sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: derives frame/move strobes from vsync and runs the
// serve / rally / score / game-over flow. All outputs are registered.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCORE_LIMIT  = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MOVE_DIV     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_vsync,
  input  logic               i_start,
  input  logic               i_p1_miss,
  input  logic               i_p2_miss,
  output logic               o_frame_tick,
  output logic               o_move_tick,
  output logic               o_ball_hold,
  output logic               o_game_active,
  output logic [SCORE_W-1:0] o_p1_score,
  output logic [SCORE_W-1:0] o_p2_score,
  output logic [1:0]         o_winner
);

  logic vs_rise, st_rise;

  state_t             state_q, state_nxt;
  logic [7:0]         serve_cnt_q, serve_cnt_nxt;
  logic [3:0]         move_cnt_q, move_cnt_nxt;
  logic [SCORE_W-1:0] p1_q, p1_nxt, p2_q, p2_nxt;
  logic [1:0]         winner_q, winner_nxt;
  logic               pend_p1_q, pend_p1_nxt;
  logic               frame_tick_q, move_tick_q, move_tick_nxt;
  logic               hold_q, active_q;

  rise_edge_det u_vsync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .sig     (i_vsync),
    .rise    (vs_rise)
  );

  rise_edge_det u_start_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .sig     (i_start),
    .rise    (st_rise)
  );

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_LIMIT)) ? s : s + SCORE_W'(1);
  endfunction

  always_comb begin
    state_nxt     = state_q;
    serve_cnt_nxt = serve_cnt_q;
    move_cnt_nxt  = move_cnt_q;
    p1_nxt        = p1_q;
    p2_nxt        = p2_q;
    winner_nxt    = winner_q;
    pend_p1_nxt   = pend_p1_q;
    move_tick_nxt = 1'b0;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (st_rise) begin
          p1_nxt        = '0;
          p2_nxt        = '0;
          winner_nxt    = WIN_NONE;
          serve_cnt_nxt = '0;
          state_nxt     = SERVE;
        end
      end
      SERVE: begin
        // Serve counts the registered frame tick, so RUNNING starts the cycle after it.
        if (frame_tick_q) begin
          serve_cnt_nxt = serve_cnt_q + 8'd1;
          if (serve_cnt_q == 8'(SERVE_FRAMES - 1)) begin
            state_nxt    = RUNNING;
            move_cnt_nxt = '0;
          end
        end
      end
      RUNNING: begin
        // Move tick is computed from the raw edge so it lands alongside o_frame_tick.
        if (vs_rise) begin
          move_cnt_nxt  = (move_cnt_q == 4'(MOVE_DIV - 1)) ? 4'd0 : move_cnt_q + 4'd1;
          move_tick_nxt = (move_cnt_q == 4'(MOVE_DIV - 1)) && !(i_p1_miss || i_p2_miss);
        end
        if (i_p1_miss && i_p2_miss) begin
          serve_cnt_nxt = '0;
          state_nxt     = SERVE;
        end else if (i_p1_miss || i_p2_miss) begin
          pend_p1_nxt = i_p2_miss;
          state_nxt   = SCORE;
        end
      end
      SCORE: begin
        if (pend_p1_q) p1_nxt = sat_inc(p1_q);
        else           p2_nxt = sat_inc(p2_q);
        if (pend_p1_q && p1_nxt == SCORE_W'(SCORE_LIMIT)) begin
          winner_nxt = WIN_P1;
          state_nxt  = GAME_OVER;
        end else if (!pend_p1_q && p2_nxt == SCORE_W'(SCORE_LIMIT)) begin
          winner_nxt = WIN_P2;
          state_nxt  = GAME_OVER;
        end else begin
          serve_cnt_nxt = '0;
          state_nxt     = SERVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      serve_cnt_q  <= '0;
      move_cnt_q   <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      winner_q     <= WIN_NONE;
      pend_p1_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      move_tick_q  <= 1'b0;
      hold_q       <= 1'b1;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      serve_cnt_q  <= serve_cnt_nxt;
      move_cnt_q   <= move_cnt_nxt;
      p1_q         <= p1_nxt;
      p2_q         <= p2_nxt;
      winner_q     <= winner_nxt;
      pend_p1_q    <= pend_p1_nxt;
      frame_tick_q <= vs_rise;
      move_tick_q  <= move_tick_nxt;
      hold_q       <= (state_nxt != RUNNING);
      active_q     <= (state_nxt == RUNNING);
    end
  end

  assign o_frame_tick  = frame_tick_q;
  assign o_move_tick   = move_tick_q;
  assign o_ball_hold   = hold_q;
  assign o_game_active = active_q;
  assign o_p1_score    = p1_q;
  assign o_p2_score    = p2_q;
  assign o_winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a frame-level game model checked every cycle,
// plus literal expectations at the key moments of each scenario.
module tb_pong_game_ctrl;

  localparam int LIM = 3;
  localparam int SF  = 3;
  localparam int MD  = 2;

  localparam int P_IDLE = 0, P_SERVE = 1, P_RUN = 2, P_SCORE = 3, P_OVER = 4;

  logic       clk = 1'b0;
  logic       rst_n, vsync, start, p1_miss, p2_miss;
  logic       frame_tick, move_tick, ball_hold, game_active;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;
  int mt_count = 0;

  pong_game_ctrl #(.SCORE_LIMIT(LIM), .SERVE_FRAMES(SF), .MOVE_DIV(MD)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_vsync       (vsync),
    .i_start       (start),
    .i_p1_miss     (p1_miss),
    .i_p2_miss     (p2_miss),
    .o_frame_tick  (frame_tick),
    .o_move_tick   (move_tick),
    .o_ball_hold   (ball_hold),
    .o_game_active (game_active),
    .o_p1_score    (p1_score),
    .o_p2_score    (p2_score),
    .o_winner      (winner)
  );

  always #20 clk = ~clk;

  // Game model: tracks phase, frames seen while serving and frames seen in the rally.
  int m_phase, m_p1, m_p2, m_win, m_serve_frames, m_rally_frames, m_pending;
  bit m_ft, m_mt, m_vs_prev, m_st_prev;

  always @(posedge clk) begin
    bit vrise, srise, new_mt;
    if (!rst_n) begin
      m_phase = P_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0;
      m_serve_frames = 0; m_rally_frames = 0; m_pending = 0;
      m_ft = 0; m_mt = 0; m_vs_prev = 1; m_st_prev = 1;
    end else begin
      vrise = vsync && !m_vs_prev;
      srise = start && !m_st_prev;
      m_vs_prev = vsync;
      m_st_prev = start;
      new_mt = 0;
      case (m_phase)
        P_IDLE, P_OVER: if (srise) begin
          m_p1 = 0; m_p2 = 0; m_win = 0; m_serve_frames = 0; m_phase = P_SERVE;
        end
        P_SERVE: if (m_ft) begin
          m_serve_frames++;
          if (m_serve_frames == SF) begin m_phase = P_RUN; m_rally_frames = 0; end
        end
        P_RUN: begin
          if (vrise) begin
            m_rally_frames++;
            new_mt = (m_rally_frames % MD == 0) && !(p1_miss || p2_miss);
          end
          if (p1_miss && p2_miss) begin m_phase = P_SERVE; m_serve_frames = 0; end
          else if (p1_miss) begin m_pending = 2; m_phase = P_SCORE; end
          else if (p2_miss) begin m_pending = 1; m_phase = P_SCORE; end
        end
        P_SCORE: begin
          if (m_pending == 1) m_p1 = (m_p1 < LIM) ? m_p1 + 1 : LIM;
          else                m_p2 = (m_p2 < LIM) ? m_p2 + 1 : LIM;
          if (m_p1 == LIM || m_p2 == LIM) begin
            m_win = m_pending; m_phase = P_OVER;
          end else begin
            m_phase = P_SERVE; m_serve_frames = 0;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      m_ft = vrise;
      m_mt = new_mt;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("frame_tick",  frame_tick,  m_ft);
      chk("move_tick",   move_tick,   m_mt);
      chk("ball_hold",   ball_hold,   m_phase != P_RUN);
      chk("game_active", game_active, m_phase == P_RUN);
      chk("p1_score",    p1_score,    m_p1);
      chk("p2_score",    p2_score,    m_p2);
      chk("winner",      winner,      m_win);
      if (move_tick === 1'b1) mt_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b0; tick(4);
    vsync = 1'b1; tick(4);
  endtask

  task automatic serve_frames();
    repeat (SF) frame();
  endtask

  task automatic miss(input bit a, input bit b);
    p1_miss = a; p2_miss = b; tick(1);
    p1_miss = 1'b0; p2_miss = 1'b0; tick(3);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1; start = 1'b0; p1_miss = 1'b0; p2_miss = 1'b0;
    tick(1);
    check_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("lit_no_tick_after_reset", frame_tick, 0);
    chk("lit_reset_hold", ball_hold, 1);
    chk("lit_reset_p1", p1_score, 0);

    // First vsync edge: single tick one cycle after vsync is first sampled high.
    vsync = 1'b0; tick(4); vsync = 1'b1;
    @(negedge clk) chk("lit_ft_pre", frame_tick, 0);
    @(negedge clk) chk("lit_ft_first", frame_tick, 1);
    @(negedge clk) chk("lit_ft_single", frame_tick, 0);
    chk("lit_idle_hold", ball_hold, 1);
    tick(3);

    // Start held high: one edge only; a start pulse in SERVE is ignored.
    start = 1'b1; tick(10); start = 1'b0; tick(2);
    frame();
    start = 1'b1; tick(2); start = 1'b0; tick(2);
    frame(); frame();
    chk("lit_running_active", game_active, 1);
    chk("lit_running_hold", ball_hold, 0);
    mt_count = 0;
    repeat (6) frame();
    chk("lit_move_ticks_6_frames", mt_count, 3);

    // Point to P1 after two cycles, then misses in SERVE are ignored.
    p2_miss = 1'b1; tick(1); p2_miss = 1'b0;
    @(negedge clk) chk("lit_p1_before", p1_score, 0);
    @(negedge clk) chk("lit_p1_after", p1_score, 1);
    chk("lit_serve_hold", ball_hold, 1);
    tick(1);
    miss(1'b1, 1'b0);
    chk("lit_serve_miss_p2", p2_score, 0);
    serve_frames();

    // Tie: no point, serve restarts.
    miss(1'b1, 1'b1);
    chk("lit_tie_p1", p1_score, 1);
    chk("lit_tie_p2", p2_score, 0);
    chk("lit_tie_hold", ball_hold, 1);
    serve_frames();

    // Miss on the rally's 2nd frame edge suppresses its move tick.
    frame();
    vsync = 1'b0; tick(4);
    vsync = 1'b1; p2_miss = 1'b1; tick(1); p2_miss = 1'b0;
    @(negedge clk);
    chk("lit_coinc_ft", frame_tick, 1);
    chk("lit_coinc_mt", move_tick, 0);
    tick(4);
    chk("lit_p1_two", p1_score, 2);
    serve_frames();

    // Third point wins; extra misses ignored; start clears.
    miss(1'b0, 1'b1);
    chk("lit_win_p1", p1_score, 3);
    chk("lit_winner", winner, 1);
    chk("lit_over_hold", ball_hold, 1);
    miss(1'b0, 1'b1);
    miss(1'b1, 1'b0);
    frame();
    chk("lit_over_frozen", p1_score, 3);
    start = 1'b1; tick(1); start = 1'b0;
    @(negedge clk);
    chk("lit_clear_p1", p1_score, 0);
    chk("lit_clear_winner", winner, 0);
    chk("lit_clear_hold", ball_hold, 1);
    tick(1);

    // Build 2/1 and reset mid-rally.
    serve_frames();
    miss(1'b0, 1'b1); serve_frames();
    miss(1'b0, 1'b1); serve_frames();
    miss(1'b1, 1'b0); serve_frames();
    chk("lit_pre_rst_p1", p1_score, 2);
    chk("lit_pre_rst_p2", p2_score, 1);
    chk("lit_pre_rst_active", game_active, 1);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_p1", p1_score, 0);
    chk("lit_rst_p2", p2_score, 0);
    chk("lit_rst_mt", move_tick, 0);
    chk("lit_rst_hold", ball_hold, 1);
    chk("lit_rst_active", game_active, 0);
    tick(1);
    frame(); frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
